// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
//
// Buffers audio frames coming from the I2S receiver so that the HPS can collect
// them over an Avalon-MM slave port. Each frame holds four 16-bit sample words
// {left1, right1, left2, right2}. The HPS reads the head frame word by word and
// pops it with a write to register 5. An interrupt is raised when the fill level
// reaches a programmable threshold or when frames have been dropped.
//
// Parameters
//   DEPTH      FIFO capacity in frames (power of two, 4..64)
//   THRESH     reset value of the irq threshold, in frames
//
// Ports
//   clk        single clock (50 MHz)
//   reset      asynchronous, active-low reset
//   in_left1, in_right1, in_left2, in_right2
//              sample words from the I2S receiver
//   in_valid   one-clk strobe, the four in_* words form a frame this cycle
//   chipselect, read, write, address, writedata
//              Avalon-MM slave controls
//   readdata   registered read data (1-cycle latency, holds when idle)
//   irq        registered level-sensitive interrupt
//
// Register map
//   0..3  R   head frame left1/right1/left2/right2 (0 when empty, no pop)
//   4     R   STATUS {4'b0, irq, overflow, full, empty, 1'b0, level[6:0]}
//   5     W   pop head frame                         (reads 0)
//   6     RW  CTRL {irq_en, 8'b0, thresh[6:0]}
//   7     RW  read: {8'b0, drops}; write: clear overflow and drops
// -----------------------------------------------------------------------------
module sample_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned THRESH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_left1,
   input  logic [15:0] in_right1,
   input  logic [15:0] in_left2,
   input  logic [15:0] in_right2,
   input  logic        in_valid,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [2:0]  address,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   // ---------------------------------------------------------------------------
   // Reset release synchroniser. Assertion is asynchronous through the state
   // registers themselves; release only enables activity once two clk edges
   // have seen reset high, keeping the first accepted push well clear of the
   // release edge.
   // ---------------------------------------------------------------------------
   logic sync_q1;
   logic run;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q1 <= 1'b0;
         run     <= 1'b0;
      end else begin
         sync_q1 <= 1'b1;
         run     <= sync_q1;
      end
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic          overflow;
   logic [7:0]    drops;
   logic [6:0]    thresh;
   logic          irq_en;

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   logic        bus_wr;
   logic        bus_rd;
   logic        full;
   logic        empty;
   logic        pop;
   logic        push;
   logic        drop;
   logic        clr;
   logic        ctrl_wr;
   logic [6:0]  level7;
   logic [6:0]  thresh_eff;
   logic        irq_next;
   logic [63:0] head;
   logic [15:0] status;
   logic [15:0] rd_mux;
   logic        unused_wdata;

   assign unused_wdata = ^writedata[14:7];

   assign bus_wr  = run & chipselect & write;
   assign bus_rd  = run & chipselect & read;

   // Occupancy flags come from the level counter only; pointer equality is
   // ambiguous between full and empty.
   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);

   assign pop     = bus_wr & (address == 3'd5) & ~empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO is still
   // accepted when it coincides with a pop.
   assign push    = run & in_valid & (~full | pop);
   assign drop    = run & in_valid & full & ~pop;
   assign clr     = bus_wr & (address == 3'd7);
   assign ctrl_wr = bus_wr & (address == 3'd6);

   assign level7  = 7'(level);
   assign head    = mem[rd_ptr];

   // Threshold of zero would make irq permanently asserted; treat it as one.
   // Thresholds beyond capacity could never be reached; clamp to DEPTH.
   always_comb begin
      thresh_eff = thresh;
      if (thresh == 7'd0) begin
         thresh_eff = 7'd1;
      end else if (thresh > 7'(DEPTH)) begin
         thresh_eff = 7'(DEPTH);
      end
   end

   assign irq_next = irq_en & ((level7 >= thresh_eff) | overflow);

   assign status = {4'b0000, irq, overflow, full, empty, 1'b0, level7};

   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0:    if (!empty) rd_mux = head[63:48];
         3'd1:    if (!empty) rd_mux = head[47:32];
         3'd2:    if (!empty) rd_mux = head[31:16];
         3'd3:    if (!empty) rd_mux = head[15:0];
         3'd4:    rd_mux = status;
         3'd6:    rd_mux = {irq_en, 8'h00, thresh};
         3'd7:    rd_mux = {8'h00, drops};
         default: rd_mux = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Frame storage (contents are not reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_left1, in_right1, in_left2, in_right2};
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers and level
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         // DEPTH is a power of two, so natural pointer overflow is the wrap.
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Overflow flag and saturating drop counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         drops    <= '0;
      end else if (clr) begin
         // A drop coinciding with the clear is counted as the first new drop.
         overflow <= drop;
         drops    <= drop ? 8'd1 : 8'd0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drops != 8'hFF) drops <= drops + 8'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Control register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         thresh <= 7'(THRESH);
         irq_en <= 1'b1;
      end else if (ctrl_wr) begin
         thresh <= writedata[6:0];
         irq_en <= writedata[15];
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
         irq <= irq_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readdata <= '0;
      end else if (bus_rd) begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_sample_fifo
//
// Directed self-checking bench for sample_fifo (DEPTH=16, THRESH=8). Inputs are
// driven 1 ns after the rising edge and outputs sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sample_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_left1;
   logic [15:0] in_right1;
   logic [15:0] in_left2;
   logic [15:0] in_right2;
   logic        in_valid;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [2:0]  address;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   sample_fifo #(.DEPTH(16), .THRESH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_left1   (in_left1),
      .in_right1  (in_right1),
      .in_left2   (in_left2),
      .in_right2  (in_right2),
      .in_valid   (in_valid),
      .chipselect (chipselect),
      .read       (read),
      .write      (write),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #10 clk = ~clk;

   // STATUS = {4'b0, irq, overflow, full, empty, 1'b0, level[6:0]}
   localparam logic [15:0] ST_EMPTY = 16'h0100;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      address    = 3'd0;
      writedata  = 16'h0000;
   endtask

   task automatic set_frame(input logic [63:0] f);
      in_left1  = f[63:48];
      in_right1 = f[47:32];
      in_left2  = f[31:16];
      in_right2 = f[15:0];
      in_valid  = 1'b1;
   endtask

   task automatic push(input logic [63:0] f);
      set_frame(f);
      tick();
      idle();
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = a;
      writedata  = d;
      tick();
      idle();
   endtask

   // Push and a register write in the same cycle.
   task automatic push_wr(input logic [63:0] f, input logic [2:0] a);
      set_frame(f);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = a;
      tick();
      idle();
   endtask

   task automatic check_rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = a;
      tick();
      idle();
      check(tag, readdata, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      in_left1 = '0; in_right1 = '0; in_left2 = '0; in_right2 = '0;
      reset = 1'b0;
      repeat (3) tick();
      check("rst_readdata", readdata, 16'h0000);
      check("rst_irq", {15'b0, irq}, 16'h0000);

      // Push presented on the first edge after release must be ignored.
      reset = 1'b1;
      set_frame(64'hDEAD_BEEF_DEAD_BEEF);
      tick();
      idle();
      repeat (3) tick();
      check_rd("sync_status", 3'd4, ST_EMPTY);
      check_rd("rst_ctrl", 3'd6, 16'h8008);
      check_rd("empty_head", 3'd0, 16'h0000);

      // Basic push / read / pop
      push(64'h1111_2222_3333_4444);
      push(64'h5555_6666_7777_8888);
      wr(3'd0, 16'hFFFF);
      wr(3'd4, 16'hFFFF);
      check_rd("f1_l1", 3'd0, 16'h1111);
      check_rd("f1_r1", 3'd1, 16'h2222);
      check_rd("f1_l2", 3'd2, 16'h3333);
      check_rd("f1_r2", 3'd3, 16'h4444);
      check_rd("status_l2", 3'd4, 16'h0002);
      check_rd("addr5_read", 3'd5, 16'h0000);
      wr(3'd5, 16'h0000);
      check_rd("f2_l1", 3'd0, 16'h5555);
      check_rd("f2_r1", 3'd1, 16'h6666);
      check_rd("f2_l2", 3'd2, 16'h7777);
      check_rd("f2_r2", 3'd3, 16'h8888);
      check_rd("status_l1", 3'd4, 16'h0001);
      wr(3'd5, 16'h0000);
      wr(3'd5, 16'h0000);
      check_rd("pop_empty", 3'd4, ST_EMPTY);

      // Threshold crossing with default thresh = 8
      for (int i = 0; i < 8; i++)
         push({16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 16'h4000 + 16'(i)});
      check("irq_pre8", {15'b0, irq}, 16'h0000);
      tick();
      check("irq_at8", {15'b0, irq}, 16'h0001);
      check_rd("status_l8", 3'd4, 16'h0808);
      wr(3'd5, 16'h0000);
      check("irq_hold", {15'b0, irq}, 16'h0001);
      tick();
      check("irq_fall", {15'b0, irq}, 16'h0000);

      // Fill past capacity: 9 accepted, 2 dropped
      for (int k = 8; k < 19; k++)
         push({16'h1000 + 16'(k), 16'h2000 + 16'(k), 16'h3000 + 16'(k), 16'h4000 + 16'(k)});
      check_rd("status_full_ovf", 3'd4, 16'h0E10);
      check_rd("drops2", 3'd7, 16'h0002);
      wr(3'd7, 16'h0000);
      check_rd("drops_clr", 3'd7, 16'h0000);
      check_rd("status_ovf_clr", 3'd4, 16'h0A10);

      // Drop counter saturates
      for (int k = 0; k < 256; k++) push(64'h0BAD_0BAD_0BAD_0BAD);
      check_rd("drops_sat", 3'd7, 16'h00FF);
      push_wr(64'h0BAD_0BAD_0BAD_0BAD, 3'd7);
      check_rd("clr_drop_cnt", 3'd7, 16'h0001);
      check_rd("clr_drop_status", 3'd4, 16'h0E10);
      wr(3'd7, 16'h0000);
      check_rd("clr2_cnt", 3'd7, 16'h0000);

      // Push and pop together while full
      check_rd("full_head", 3'd0, 16'h1001);
      push_wr(64'hAAAA_BBBB_CCCC_DDDD, 3'd5);
      check_rd("pp_full_status", 3'd4, 16'h0A10);
      check_rd("pp_full_drops", 3'd7, 16'h0000);
      check_rd("pp_full_head", 3'd0, 16'h1002);
      repeat (15) wr(3'd5, 16'h0000);
      check_rd("pp_after15", 3'd4, 16'h0001);
      check_rd("pp_new_l1", 3'd0, 16'hAAAA);
      check_rd("pp_new_r2", 3'd3, 16'hDDDD);

      // Push and pop together while empty
      wr(3'd5, 16'h0000);
      push_wr(64'h0A0A_0B0B_0C0C_0D0D, 3'd5);
      check_rd("pp_empty_status", 3'd4, 16'h0001);
      check_rd("pp_empty_r1", 3'd1, 16'h0B0B);
      wr(3'd5, 16'h0000);

      // Threshold 0 behaves as 1; thresholds above DEPTH clamp to DEPTH
      wr(3'd6, 16'h8000);
      tick();
      check("th0_lvl0", {15'b0, irq}, 16'h0000);
      push(64'h0001_0002_0003_0004);
      check("th0_pre", {15'b0, irq}, 16'h0000);
      tick();
      check("th0_lvl1", {15'b0, irq}, 16'h0001);
      wr(3'd6, 16'h807F);
      tick();
      check("th127_lvl1", {15'b0, irq}, 16'h0000);
      for (int k = 0; k < 14; k++) push(64'h0101_0202_0303_0404);
      tick();
      check("th127_lvl15", {15'b0, irq}, 16'h0000);
      push(64'h0101_0202_0303_0404);
      tick();
      check("th127_lvl16", {15'b0, irq}, 16'h0001);
      check_rd("ctrl_rb", 3'd6, 16'h807F);
      repeat (16) wr(3'd5, 16'h0000);
      check_rd("drained", 3'd4, ST_EMPTY);

      // irq_en gating
      wr(3'd6, 16'h0003);
      for (int i = 0; i < 4; i++)
         push({16'hC000 + 16'(i), 16'hC100 + 16'(i), 16'hC200 + 16'(i), 16'hC300 + 16'(i)});
      tick();
      check("irqen0", {15'b0, irq}, 16'h0000);
      wr(3'd6, 16'h8003);
      check("irqen1_pre", {15'b0, irq}, 16'h0000);
      tick();
      check("irqen1", {15'b0, irq}, 16'h0001);
      wr(3'd6, 16'h0003);
      tick();
      check("irqen_clr", {15'b0, irq}, 16'h0000);
      wr(3'd6, 16'h8003);
      push(64'hC004_C104_C204_C304);
      check("irq_lvl5", {15'b0, irq}, 16'h0001);
      check_rd("lvl5_head", 3'd0, 16'hC000);

      // Asynchronous reset mid-stream
      reset = 1'b0;
      #2;
      check("async_rst_rd", readdata, 16'h0000);
      check("async_rst_irq", {15'b0, irq}, 16'h0000);
      repeat (2) tick();
      reset = 1'b1;
      repeat (4) tick();
      check_rd("post_rst_status", 3'd4, ST_EMPTY);
      check_rd("post_rst_ctrl", 3'd6, 16'h8008);
      wr(3'd5, 16'h0000);
      check_rd("post_rst_pop", 3'd4, ST_EMPTY);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO capacity in frames, power of two, 4 to 64.
REQ-002 SHALL have parameter THRESH, default 8, reset value of the irq threshold, in frames.
REQ-003 SHALL have port clk  input  1  the single clock, 50 MHz.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports in_left1, in_right1, in_left2, in_right2  input  16 each  sample words from the I2S receiver, upper 16 bits of each 24-bit sample.
REQ-006 SHALL have port in_valid  input  1  one-clk pulse, synchronous to clk; the four in_* words are a valid frame in that cycle.
REQ-007 SHALL have ports chipselect, read, write  input  1 each  Avalon-MM slave controls.
REQ-008 SHALL have port address  input  3  register index.
REQ-009 SHALL have port writedata  input  16  write data.
REQ-010 SHALL have port readdata  output  16  registered read data.
REQ-011 SHALL have port irq  output  1  registered, level-sensitive interrupt to the HPS.
REQ-012 The design SHALL have one clock; reset is asynchronous and active-low.

Function
REQ-013 Frame storage: DEPTH entries of 64 bits each, holding {left1,right1,left2,right2}, with wr_ptr, rd_ptr and level counter (0..DEPTH).
REQ-014 Push: in_valid=1 and level<DEPTH writes the frame at wr_ptr; wr_ptr wraps modulo DEPTH; level+1.
REQ-015 Push while full (level=DEPTH, no pop in the same cycle): frame dropped, overflow sticky bit set, 8-bit drop counter +1, saturating at 255.
REQ-016 Pop: chipselect&write with address 5 and level>0 advances rd_ptr modulo DEPTH; level-1. Pop while empty has no effect.
REQ-017 Push and pop in the same cycle, level>0: both execute; level unchanged. This includes the full case, where the push is accepted and no drop occurs.
REQ-018 Push and pop in the same cycle with level=0: pop ignored, push accepted, level=1.
REQ-019 Read map (chipselect&read; readdata updates at the next clk edge, 1-cycle latency):
- 0..3: head-frame left1, right1, left2, right2; reads 0 when empty; reading does not pop.
- 4: STATUS = {4'b0, irq, overflow, full, empty, 1'b0, level[6:0]}.
- 6: CTRL = {irq_en, 8'b0, thresh[6:0]}.
- 7: {8'b0, drops[7:0]}.
- 5: reads 0.
REQ-020 readdata SHALL hold its value when no read is issued.
REQ-021 Write map:
- 5: pop.
- 6: thresh <= writedata[6:0]; irq_en <= writedata[15].
- 7: clear overflow and drops; a drop in the same cycle wins, leaving overflow=1 and drops=1.
- 0..4: ignored.
REQ-022 Effective threshold SHALL be max(thresh,1); values above DEPTH SHALL be clamped to DEPTH.
REQ-023 irq SHALL register irq_en & ((level >= effective threshold) | overflow), computed from the current-cycle level, so it asserts one clk after the crossing push.
REQ-024 irq SHALL deassert one clk after level drops below threshold with overflow clear, or after irq_en is cleared.
REQ-025 full = (level==DEPTH); empty = (level==0); both derived from level, never from pointer equality alone.

Reset
REQ-026 On reset low, SHALL asynchronously set wr_ptr=0, rd_ptr=0, level=0, overflow=0, drops=0, readdata=0, irq=0, thresh=THRESH, irq_en=1.
REQ-027 Storage contents need not be reset. Reset asserted mid-operation discards all buffered frames.
REQ-028 Reset release SHALL be synchronised to clk, so the first push is accepted no earlier than the second clk edge after release.

Verification
REQ-029 Push frames {0x1111,0x2222,0x3333,0x4444} then {0x5555,...}; read addresses 0..3 -> 0x1111..0x4444; pop; re-read -> 0x5555...; STATUS level 2 then 1.
REQ-030 Push 8 frames with default thresh -> irq rises one clk after the 8th push; one pop -> irq falls one clk later.
REQ-031 Push 18 frames without popping -> STATUS full=1, overflow=1; addr7 reads 2; write addr7 -> reads 0, overflow=0.
REQ-032 With level=16, push and pop in the same cycle -> level stays 16, drops unchanged, and the new frame is read after 15 further pops.
REQ-033 Write CTRL 0x0003 (irq_en=0, thresh=3), push 4 frames -> irq stays 0; write CTRL 0x8003 -> irq=1 one clk later.
REQ-034 Assert reset mid-stream with level=5 -> level=0, irq=0, readdata=0 immediately without waiting for a clk edge; pop while empty -> level stays 0.
